// File: rtl/ex_pkg.sv
// Shared constants for the execute stage: ALU opcodes, branch funct3 codes,
// forwarding selects and the multiplier FSM state type.
package ex_pkg;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_SLL    = 4'd2;
    localparam logic [3:0] ALU_SLT    = 4'd3;
    localparam logic [3:0] ALU_SLTU   = 4'd4;
    localparam logic [3:0] ALU_XOR    = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_OR     = 4'd8;
    localparam logic [3:0] ALU_AND    = 4'd9;
    localparam logic [3:0] ALU_PASSB  = 4'd10;
    localparam logic [3:0] ALU_MUL    = 4'd11;
    localparam logic [3:0] ALU_MULH   = 4'd12;
    localparam logic [3:0] ALU_MULHSU = 4'd13;
    localparam logic [3:0] ALU_MULHU  = 4'd14;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_MULHSU) || (op == ALU_MULHU);
    endfunction

endpackage

// File: rtl/ex_alu.sv
// Combinational ALU plus the RV32I branch comparator (opA against the
// forwarded rs2 value, independent of the immediate select).
module ex_alu
    import ex_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [XLEN-1:0] cmp_b,
    input  logic [3:0]      alu_op,
    input  logic [2:0]      br_funct3,
    output logic [XLEN-1:0] result,
    output logic            br_cond
);

    logic [SHAMT_W-1:0] shamt;
    logic               eq, lt, ltu;

    assign shamt = op_b[SHAMT_W-1:0];

    always_comb begin
        result = op_a + op_b;
        case (alu_op)
            ALU_SUB:   result = op_a - op_b;
            ALU_SLL:   result = op_a << shamt;
            ALU_SLT:   result = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            ALU_SLTU:  result = {{(XLEN-1){1'b0}}, op_a < op_b};
            ALU_XOR:   result = op_a ^ op_b;
            ALU_SRL:   result = op_a >> shamt;
            ALU_SRA:   result = $unsigned($signed(op_a) >>> shamt);
            ALU_OR:    result = op_a | op_b;
            ALU_AND:   result = op_a & op_b;
            ALU_PASSB: result = op_b;
            default:   result = op_a + op_b;
        endcase
    end

    assign eq  = op_a == cmp_b;
    assign lt  = $signed(op_a) < $signed(cmp_b);
    assign ltu = op_a < cmp_b;

    // Reserved funct3 codes 010/011 resolve as not taken.
    always_comb begin
        br_cond = 1'b0;
        case (br_funct3)
            F3_BEQ:  br_cond = eq;
            F3_BNE:  br_cond = ~eq;
            F3_BLT:  br_cond = lt;
            F3_BGE:  br_cond = ~lt;
            F3_BLTU: br_cond = ltu;
            F3_BGEU: br_cond = ~ltu;
            default: br_cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_stage_pipe.sv
// Execute stage with valid/ready on both sides, forwarding, branch resolution
// and, when EX_MUL_EN is defined, an iterative shift-add multiplier.
module ex_stage_pipe
    import ex_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    in_pc,
    input  logic [XLEN-1:0]    in_rs1_data,
    input  logic [XLEN-1:0]    in_rs2_data,
    input  logic [XLEN-1:0]    in_imm,
    input  logic [RADDR_W-1:0] in_rd,
    input  logic [3:0]         in_alu_op,
    input  logic               in_alu_src,
    input  logic               in_branch,
    input  logic               in_jump,
    input  logic               in_jalr,
    input  logic [2:0]         in_br_funct3,
    input  logic               in_pred_taken,
    input  logic               in_mem_read,
    input  logic               in_mem_write,
    input  logic               in_mem_to_reg,
    input  logic               in_reg_write,
    input  logic [1:0]         fwd_a_sel,
    input  logic [1:0]         fwd_b_sel,
    input  logic [XLEN-1:0]    fwd_mem_data,
    input  logic [XLEN-1:0]    fwd_wb_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_pc,
    output logic [XLEN-1:0]    out_result,
    output logic [XLEN-1:0]    out_wdata,
    output logic [RADDR_W-1:0] out_rd,
    output logic               out_mem_read,
    output logic               out_mem_write,
    output logic               out_mem_to_reg,
    output logic               out_reg_write,
    output logic               br_valid,
    output logic               br_taken,
    output logic               br_mispredict,
    output logic [XLEN-1:0]    br_redirect_pc
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    function automatic logic [XLEN-1:0] fwd_mux(input logic [1:0] sel, input logic [XLEN-1:0] rf,
                                                input logic [XLEN-1:0] mem, input logic [XLEN-1:0] wb);
        case (sel)
            FWD_MEM: return mem;
            FWD_WB:  return wb;
            default: return rf;
        endcase
    endfunction

    logic [XLEN-1:0] op_a, rs2f, op_b, alu_result, pc_plus4, jalr_sum, br_target, ex_result;
    logic [3:0]      in_ctl;
    logic            br_cond, is_jmp, is_ctl, taken, mispredict;
    logic            busy, can_load, accept, is_mul, single_load;

    assign op_a     = fwd_mux(fwd_a_sel, in_rs1_data, fwd_mem_data, fwd_wb_data);
    assign rs2f     = fwd_mux(fwd_b_sel, in_rs2_data, fwd_mem_data, fwd_wb_data);
    assign op_b     = in_alu_src ? in_imm : rs2f;
    assign in_ctl   = {in_mem_read, in_mem_write, in_mem_to_reg, in_reg_write};
    assign pc_plus4 = in_pc + PC_STEP;

    ex_alu #(.XLEN(XLEN), .SHAMT_W(SHAMT_W)) u_alu (
        .op_a      (op_a),
        .op_b      (op_b),
        .cmp_b     (rs2f),
        .alu_op    (in_alu_op),
        .br_funct3 (in_br_funct3),
        .result    (alu_result),
        .br_cond   (br_cond)
    );

    assign is_jmp     = in_jump | in_jalr;
    assign is_ctl     = in_branch | is_jmp;
    assign taken      = is_jmp | (in_branch & br_cond);
    assign mispredict = is_ctl & (taken != in_pred_taken);
    assign jalr_sum   = op_a + in_imm;
    assign br_target  = in_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : in_pc + in_imm;
    assign ex_result  = is_jmp ? pc_plus4 : alu_result;

    logic               out_valid_q, out_valid_d;
    logic [XLEN-1:0]    out_pc_q, out_pc_d, out_result_q, out_result_d, out_wdata_q, out_wdata_d;
    logic [RADDR_W-1:0] out_rd_q, out_rd_d;
    logic [3:0]         out_ctl_q, out_ctl_d;
    logic               br_valid_q, br_valid_d, br_taken_q, br_taken_d, br_mis_q, br_mis_d;
    logic [XLEN-1:0]    br_pc_q, br_pc_d;

    // Flush blocks acceptance so the instruction presented alongside it is dropped.
    assign can_load    = ~out_valid_q | out_ready;
    assign in_ready    = ~busy & can_load & ~flush;
    assign accept      = in_valid & in_ready;
    assign single_load = accept & ~is_mul;

`ifdef EX_MUL_EN
    mul_state_e         mul_state_q;
    logic [2*XLEN-1:0]  mcand_q, acc_q, prod;
    logic [XLEN-1:0]    mplier_q, a_mag, b_mag, mul_result;
    logic [SHAMT_W-1:0] cnt_q;
    logic               neg_q, hi_q, a_signed, b_signed, a_neg, b_neg, mul_load;
    logic [XLEN-1:0]    mul_pc_q, mul_wdata_q;
    logic [RADDR_W-1:0] mul_rd_q;
    logic [3:0]         mul_ctl_q;

    // Multiply magnitudes unsigned, then restore the sign of the full product.
    assign is_mul   = is_mul_op(in_alu_op);
    assign a_signed = (in_alu_op == ALU_MULH) | (in_alu_op == ALU_MULHSU);
    assign b_signed = in_alu_op == ALU_MULH;
    assign a_neg    = a_signed & op_a[XLEN-1];
    assign b_neg    = b_signed & op_b[XLEN-1];
    assign a_mag    = a_neg ? -op_a : op_a;
    assign b_mag    = b_neg ? -op_b : op_b;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mul_state_q <= MUL_IDLE;
            mcand_q     <= '0;
            acc_q       <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            hi_q        <= 1'b0;
            mul_pc_q    <= '0;
            mul_wdata_q <= '0;
            mul_rd_q    <= '0;
            mul_ctl_q   <= '0;
        end else if (flush) begin
            mul_state_q <= MUL_IDLE;
        end else begin
            case (mul_state_q)
                MUL_IDLE: if (accept && is_mul) begin
                    mul_state_q <= MUL_BUSY;
                    mcand_q     <= {{XLEN{1'b0}}, a_mag};
                    mplier_q    <= b_mag;
                    acc_q       <= '0;
                    cnt_q       <= '0;
                    neg_q       <= a_neg ^ b_neg;
                    hi_q        <= in_alu_op != ALU_MUL;
                    mul_pc_q    <= in_pc;
                    mul_wdata_q <= rs2f;
                    mul_rd_q    <= in_rd;
                    mul_ctl_q   <= in_ctl;
                end
                MUL_BUSY: begin
                    if (mplier_q[0]) acc_q <= acc_q + mcand_q;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == SHAMT_W'(XLEN-1)) mul_state_q <= MUL_DONE;
                end
                MUL_DONE: if (can_load) mul_state_q <= MUL_IDLE;
                default:  mul_state_q <= MUL_IDLE;
            endcase
        end
    end

    assign prod       = neg_q ? -acc_q : acc_q;
    assign mul_result = hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    assign busy       = mul_state_q != MUL_IDLE;
    assign mul_load   = (mul_state_q == MUL_DONE) & can_load & ~flush;
`else
    assign is_mul = 1'b0;
    assign busy   = 1'b0;
`endif

    // Branch outputs are single-cycle pulses; they clear on every edge without a load.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_pc_d     = out_pc_q;
        out_result_d = out_result_q;
        out_wdata_d  = out_wdata_q;
        out_rd_d     = out_rd_q;
        out_ctl_d    = out_ctl_q;
        br_valid_d   = 1'b0;
        br_taken_d   = 1'b0;
        br_mis_d     = 1'b0;
        br_pc_d      = '0;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (single_load) begin
            out_valid_d  = 1'b1;
            out_pc_d     = in_pc;
            out_result_d = ex_result;
            out_wdata_d  = rs2f;
            out_rd_d     = in_rd;
            out_ctl_d    = in_ctl;
            br_valid_d   = is_ctl;
            br_taken_d   = is_ctl & taken;
            br_mis_d     = mispredict;
            br_pc_d      = mispredict ? (taken ? br_target : pc_plus4) : '0;
`ifdef EX_MUL_EN
        end else if (mul_load) begin
            out_valid_d  = 1'b1;
            out_pc_d     = mul_pc_q;
            out_result_d = mul_result;
            out_wdata_d  = mul_wdata_q;
            out_rd_d     = mul_rd_q;
            out_ctl_d    = mul_ctl_q;
`endif
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid_q  <= 1'b0;
            out_pc_q     <= '0;
            out_result_q <= '0;
            out_wdata_q  <= '0;
            out_rd_q     <= '0;
            out_ctl_q    <= '0;
            br_valid_q   <= 1'b0;
            br_taken_q   <= 1'b0;
            br_mis_q     <= 1'b0;
            br_pc_q      <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_pc_q     <= out_pc_d;
            out_result_q <= out_result_d;
            out_wdata_q  <= out_wdata_d;
            out_rd_q     <= out_rd_d;
            out_ctl_q    <= out_ctl_d;
            br_valid_q   <= br_valid_d;
            br_taken_q   <= br_taken_d;
            br_mis_q     <= br_mis_d;
            br_pc_q      <= br_pc_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_pc         = out_pc_q;
    assign out_result     = out_result_q;
    assign out_wdata      = out_wdata_q;
    assign out_rd         = out_rd_q;
    assign out_mem_read   = out_ctl_q[3];
    assign out_mem_write  = out_ctl_q[2];
    assign out_mem_to_reg = out_ctl_q[1];
    assign out_reg_write  = out_ctl_q[0];
    assign br_valid       = br_valid_q;
    assign br_taken       = br_taken_q;
    assign br_mispredict  = br_mis_q;
    assign br_redirect_pc = br_pc_q;

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Scoreboard bench for ex_stage_pipe: directed cases followed by a random
// stream; a monitor process compares every presented output against the queue.
module tb_ex_stage_pipe;

    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        reset_n, flush, in_valid, in_ready, in_alu_src, in_branch, in_jump, in_jalr;
    logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm, fwd_mem_data, fwd_wb_data;
    logic [4:0]  in_rd;
    logic [3:0]  in_alu_op;
    logic [2:0]  in_br_funct3;
    logic        in_pred_taken, in_mem_read, in_mem_write, in_mem_to_reg, in_reg_write;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic        out_valid, out_ready, out_mem_read, out_mem_write, out_mem_to_reg, out_reg_write;
    logic [31:0] out_pc, out_result, out_wdata, br_redirect_pc;
    logic [4:0]  out_rd;
    logic        br_valid, br_taken, br_mispredict;

    always #5 clk = ~clk;

    ex_stage_pipe dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .in_rd(in_rd), .in_alu_op(in_alu_op), .in_alu_src(in_alu_src), .in_branch(in_branch),
        .in_jump(in_jump), .in_jalr(in_jalr), .in_br_funct3(in_br_funct3),
        .in_pred_taken(in_pred_taken), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write), .fwd_a_sel(fwd_a_sel),
        .fwd_b_sel(fwd_b_sel), .fwd_mem_data(fwd_mem_data), .fwd_wb_data(fwd_wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_result(out_result),
        .out_wdata(out_wdata), .out_rd(out_rd), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .out_mem_to_reg(out_mem_to_reg),
        .out_reg_write(out_reg_write), .br_valid(br_valid), .br_taken(br_taken),
        .br_mispredict(br_mispredict), .br_redirect_pc(br_redirect_pc)
    );

    typedef struct {
        logic [31:0] pc, rs1, rs2, imm, fm, fw;
        logic [4:0]  rd;
        logic [3:0]  op, ctl;
        logic [2:0]  f3;
        logic [1:0]  fa, fb;
        logic        src, br, jmp, jalr, pred;
    } txn_t;
    typedef struct { logic [31:0] pc, result, wdata; logic [4:0] rd; logic [3:0] ctl; } exp_t;
    typedef struct { int cyc; logic taken, mis; logic [31:0] rpc; } bexp_t;

    exp_t  sbq[$];
    bexp_t brq[$];
    int    checks = 0, errors = 0, cyc = 0;
    logic  m_ov = 1'b0;
    int    m_state = 0, m_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic is_mul(input logic [3:0] op);
`ifdef EX_MUL_EN
        return op >= 4'd11 && op <= 4'd14;
`else
        return op != op;
`endif
    endfunction

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf, mem, wb);
        if (sel == 2'b10) return mem;
        if (sel == 2'b01) return wb;
        return rf;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, p;
        logic [63:0]        ua, ub;
        int                 sh;
        sa = $signed(a); sb = $signed(b); ua = {32'd0, a}; ub = {32'd0, b}; sh = int'(b[4:0]);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a << sh;
            4'd3:  return {31'd0, $signed(a) < $signed(b)};
            4'd4:  return {31'd0, a < b};
            4'd5:  return a ^ b;
            4'd6:  return a >> sh;
            4'd7:  return $signed(a) >>> sh;
            4'd8:  return a | b;
            4'd9:  return a & b;
            4'd10: return b;
`ifdef EX_MUL_EN
            4'd11: begin p = sa * sb; return p[31:0]; end
            4'd12: begin p = sa * sb; return p[63:32]; end
            4'd13: begin p = sa * $signed(ub); return p[63:32]; end
            4'd14: begin ua = ua * ub; return ua[63:32]; end
`endif
            default: return a + b;
        endcase
    endfunction

    function automatic logic ref_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000: return a == b;
            3'b001: return a != b;
            3'b100: return $signed(a) < $signed(b);
            3'b101: return $signed(a) >= $signed(b);
            3'b110: return a < b;
            3'b111: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // Reference model: push the output and (for control transfers) the branch pulse.
    task automatic predict(input txn_t t);
        logic [31:0] a, r2, b, tgt, res;
        logic        tk, mis;
        exp_t        e;
        bexp_t       be;
        a   = pick(t.fa, t.rs1, t.fm, t.fw);
        r2  = pick(t.fb, t.rs2, t.fm, t.fw);
        b   = t.src ? t.imm : r2;
        res = (t.jmp || t.jalr) ? t.pc + 32'd4 : ref_alu(t.op, a, b);
        e.pc = t.pc; e.result = res; e.wdata = r2; e.rd = t.rd; e.ctl = t.ctl;
        sbq.push_back(e);
        if (t.br || t.jmp || t.jalr) begin
            tk  = t.jmp || t.jalr || ref_cond(t.f3, a, r2);
            tgt = t.jalr ? ((a + t.imm) & 32'hFFFF_FFFE) : t.pc + t.imm;
            mis = tk != t.pred;
            be.cyc = cyc + 1; be.taken = tk; be.mis = mis;
            be.rpc = !mis ? 32'd0 : (tk ? tgt : t.pc + 32'd4);
            brq.push_back(be);
        end
    endtask

    task automatic drive(input txn_t t);
        in_pc = t.pc; in_rs1_data = t.rs1; in_rs2_data = t.rs2; in_imm = t.imm; in_rd = t.rd;
        in_alu_op = t.op; in_alu_src = t.src; in_branch = t.br; in_jump = t.jmp; in_jalr = t.jalr;
        in_br_funct3 = t.f3; in_pred_taken = t.pred; fwd_a_sel = t.fa; fwd_b_sel = t.fb;
        fwd_mem_data = t.fm; fwd_wb_data = t.fw;
        {in_mem_read, in_mem_write, in_mem_to_reg, in_reg_write} = t.ctl;
    endtask

    // One clock cycle of stimulus; returns at the rising edge that ends it.
    task automatic step(input txn_t t, input logic v, input logic fl, input logic rdy, output logic acc);
        logic exp_rdy, mul_op, load;
        @(negedge clk);
        reset_n = 1'b1; drive(t); in_valid = v; flush = fl; out_ready = rdy;
        #1;
        exp_rdy = (m_state == 0) && (!m_ov || rdy) && !fl;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        acc    = v && exp_rdy;
        mul_op = is_mul(t.op);
        if (acc) predict(t);
        if (fl && m_state != 0) void'(sbq.pop_back());
        @(posedge clk);
        load = 1'b0;
        if (fl) begin
            m_ov = 1'b0; m_state = 0;
        end else begin
            case (m_state)
                0: if (acc && mul_op) begin m_state = 1; m_cnt = XLEN; end
                1: begin m_cnt--; if (m_cnt == 0) m_state = 2; end
                default: if (!m_ov || rdy) begin m_state = 0; load = 1'b1; end
            endcase
            if ((acc && !mul_op) || load) m_ov = 1'b1;
            else if (rdy) m_ov = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        sbq.delete(); brq.delete();
        @(posedge clk);
        #1;
        m_ov = 1'b0; m_state = 0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_wdata", out_wdata, 32'd0);
        chk("rst_out_rd_ctl", {23'd0, out_rd, out_mem_read, out_mem_write, out_mem_to_reg, out_reg_write}, 32'd0);
        chk("rst_br", {29'd0, br_valid, br_taken, br_mispredict}, 32'd0);
        chk("rst_redirect", br_redirect_pc, 32'd0);
    endtask

    function automatic txn_t nop_txn();
        txn_t t;
        t.pc = 32'h0; t.rs1 = 32'h0; t.rs2 = 32'h0; t.imm = 32'h0; t.fm = 32'h0; t.fw = 32'h0;
        t.rd = 5'd0; t.op = 4'd0; t.ctl = 4'd0; t.f3 = 3'd0; t.fa = 2'd0; t.fb = 2'd0;
        t.src = 1'b0; t.br = 1'b0; t.jmp = 1'b0; t.jalr = 1'b0; t.pred = 1'b0;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        int   k;
        t = nop_txn();
        t.pc  = $urandom & 32'hFFFF_FFFC;
        t.rs1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) - 32'd20 : $urandom;
        t.rs2 = ($urandom_range(0, 3) == 0) ? t.rs1 : $urandom;
        t.imm = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 4095)) - 32'd2048 : $urandom;
        t.fm = $urandom; t.fw = $urandom; t.rd = 5'($urandom); t.op = 4'($urandom);
        t.ctl = 4'($urandom); t.f3 = 3'($urandom); t.fa = 2'($urandom); t.fb = 2'($urandom);
        t.src = 1'($urandom); t.pred = 1'($urandom);
        k = $urandom_range(0, 9);
        t.br = k < 2; t.jmp = k == 2 || k == 3; t.jalr = k == 3;
        if (is_mul(t.op)) begin
            if ($urandom_range(0, 7) != 0) t.op = 4'd0;
            else begin t.br = 1'b0; t.jmp = 1'b0; t.jalr = 1'b0; end
        end
        return t;
    endfunction

    // Monitor: compares whatever the DUT presents against the head of the scoreboard.
    initial begin
        exp_t  e;
        bexp_t b;
        forever begin
            @(negedge clk);
            #2;
            if (reset_n === 1'b1) begin
                if (out_valid) begin
                    if (sbq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL out_valid: got 1 expected 0 (nothing pending, cycle %0d)", cyc);
                    end else begin
                        e = sbq[0];
                        chk("out_pc", out_pc, e.pc);
                        chk("out_result", out_result, e.result);
                        chk("out_wdata", out_wdata, e.wdata);
                        chk("out_rd_ctl", {23'd0, out_rd, out_mem_read, out_mem_write, out_mem_to_reg, out_reg_write},
                            {23'd0, e.rd, e.ctl});
                        if (out_ready || flush) void'(sbq.pop_front());
                    end
                end
                if (brq.size() > 0 && brq[0].cyc == cyc) begin
                    b = brq.pop_front();
                    chk("br_pulse", {29'd0, br_valid, br_taken, br_mispredict}, {29'd0, 1'b1, b.taken, b.mis});
                    chk("br_redirect", br_redirect_pc, b.rpc);
                end else begin
                    chk("br_idle", {29'd0, br_valid, br_taken, br_mispredict}, 32'd0);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t t;
        logic acc;
        int   k;
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive(nop_txn());
        do_reset();

        // Forwarding from MEM into operand A.
        t = nop_txn(); t.rs1 = 32'd5; t.rs2 = 32'd7; t.fa = 2'b10; t.fm = 32'd100; t.rd = 5'd3; t.ctl = 4'b0001;
        step(t, 1'b1, 1'b0, 1'b1, acc);
        chk("fwd_accept", 32'(acc), 32'd1);
        #1;
        chk("fwd_latency", 32'(out_valid), 32'd1);
        chk("fwd_result", out_result, 32'd107);

        // BLT taken but predicted not-taken.
        t = nop_txn(); t.pc = 32'h100; t.imm = 32'h20; t.rs1 = 32'hFFFF_FFFF; t.rs2 = 32'd1;
        t.br = 1'b1; t.f3 = 3'b100; t.pred = 1'b0;
        step(t, 1'b1, 1'b0, 1'b1, acc);
        #1;
        chk("blt_mispredict", 32'(br_mispredict), 32'd1);
        chk("blt_redirect", br_redirect_pc, 32'h120);

        // BGEU with the same data is taken, so a taken prediction is correct.
        t.f3 = 3'b111; t.pred = 1'b1;
        step(t, 1'b1, 1'b0, 1'b1, acc);
        #1;
        chk("bgeu_redirect", br_redirect_pc, 32'h0);

        // BLTU not taken while predicted taken: fall through.
        t.f3 = 3'b110; t.pred = 1'b1;
        step(t, 1'b1, 1'b0, 1'b1, acc);
        #1;
        chk("bltu_redirect", br_redirect_pc, 32'h104);

        // JALR clears target bit 0 and links pc+4.
        t = nop_txn(); t.pc = 32'h400; t.rs1 = 32'h2003; t.imm = 32'd4; t.jmp = 1'b1; t.jalr = 1'b1; t.rd = 5'd1;
        step(t, 1'b1, 1'b0, 1'b1, acc);
        #1;
        chk("jalr_result", out_result, 32'h404);
        chk("jalr_redirect", br_redirect_pc, 32'h2006);

        // Back-pressure: held output blocks input, release accepts in the same cycle.
        t = rand_txn(); t.op = 4'd1;
        step(t, 1'b1, 1'b0, 1'b0, acc);
        t = rand_txn(); t.op = 4'd5;
        for (int i = 0; i < 3; i++) begin
            step(t, 1'b1, 1'b0, 1'b0, acc);
            chk("bp_blocked", 32'(acc), 32'd0);
        end
        step(t, 1'b1, 1'b0, 1'b1, acc);
        chk("bp_release_accept", 32'(acc), 32'd1);

        // Reset in the middle of a stalled stream.
        step(rand_txn(), 1'b1, 1'b0, 1'b0, acc);
        do_reset();

`ifdef EX_MUL_EN
        t = nop_txn(); t.op = 4'd14; t.rs1 = 32'hFFFF_FFFF; t.rs2 = 32'hFFFF_FFFF; t.rd = 5'd9;
        step(t, 1'b1, 1'b0, 1'b1, acc);
        k = 0;
        for (int i = 1; i <= 100; i++) begin
            step(nop_txn(), 1'b1, 1'b0, 1'b1, acc);
            #1;
            if (out_valid) begin k = i; break; end
        end
        chk("mul_latency", 32'(k), 32'(XLEN + 1));
        chk("mulhu_result", out_result, 32'hFFFF_FFFE);
        step(nop_txn(), 1'b0, 1'b0, 1'b1, acc);
        step(t, 1'b1, 1'b0, 1'b1, acc);
        for (int i = 0; i < 10; i++) step(nop_txn(), 1'b1, 1'b0, 1'b1, acc);
        step(nop_txn(), 1'b0, 1'b1, 1'b1, acc);
        for (int i = 0; i < 40; i++) step(nop_txn(), 1'b0, 1'b0, 1'b1, acc);
`endif

        // Random stream with random valid, ready and occasional flush.
        for (int i = 0; i < 400; i++) begin
            step(rand_txn(), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 3) != 0), acc);
        end

        for (int i = 0; i < 200 && (sbq.size() > 0 || brq.size() > 0 || m_state != 0); i++)
            step(nop_txn(), 1'b0, 1'b0, 1'b1, acc);
        step(nop_txn(), 1'b0, 1'b0, 1'b1, acc);
        chk("drain_empty", 32'(sbq.size() + brq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
